pq_arbiter: RTL and testbench
=============================

PQ_ARBITER -- requirements
Module: pq_arbiter

Interface
REQ-001 Parameter W, default 8, data width of every value path.
REQ-002 Parameter DEPTH, default 6, queue capacity in entries.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset_L  input  1  reset, asynchronous, active-low.
REQ-005 p0_valid, p1_valid  input  1 each  producer n offers p{n}_data.
REQ-006 p0_data, p1_data  input  W each  producer insert values.
REQ-007 p0_ready, p1_ready  output  1 each  one-cycle accept pulse to producer n.
REQ-008 c_req  input  1  consumer requests removal of the highest value.
REQ-009 c_valid  output  1  one-cycle pulse; c_data is valid.
REQ-010 c_data  output  W  value removed from the queue.
REQ-011 c_err  output  1  one-cycle pulse; c_req was made while the queue was empty.
REQ-012 clear_req  input  1  flush the queue.
REQ-013 q_val  output  W  value to insert into the queue.
REQ-014 q_ins, q_pop, q_clr  output  1 each  one-cycle command strobes to the queue.
REQ-015 q_top  input  W  current highest queue entry.
REQ-016 count  output  $clog2(DEPTH+1)  occupancy; full and empty outputs, 1 bit each.

Function
REQ-017 The FSM SHALL have four states: IDLE, INS, POP and SETTLE; exactly one queue command is issued per operation.
REQ-018 IDLE SHALL use this priority: clear_req, then c_req, then a producer insert.
REQ-019 IDLE with c_req & !empty SHALL go to POP; with c_req & empty it SHALL pulse c_err for one cycle and evaluate producers in the same cycle.
REQ-020 IDLE with no pop taken SHALL grant one valid producer when !full: pulse its ready, latch its data into q_val, and go to INS.
REQ-021 If both producers are valid, the grant SHALL go to the producer not granted last (2-way round robin); the last-grant pointer updates only on a grant.
REQ-022 INS SHALL assert q_ins for one cycle, increment count, and go to SETTLE.
REQ-023 POP SHALL register q_top into c_data, assert q_pop for one cycle, decrement count, and go to SETTLE.
REQ-024 SETTLE SHALL last one cycle and return to IDLE; c_valid pulses in SETTLE only when the preceding state was POP.
REQ-025 Every operation SHALL take 3 cycles: IDLE accept, INS/POP, SETTLE.
REQ-026 Producer ready SHALL never assert while full is high; c_req SHALL never produce q_pop while empty is high.
REQ-027 full SHALL be high exactly when count==DEPTH, and empty exactly when count==0; count SHALL never wrap.
REQ-028 clear_req in any state SHALL pulse q_clr, set count to 0, suppress any pending c_valid and ready, and enter IDLE on the next cycle.
REQ-029 When full and c_req is high, the pop SHALL proceed, and the blocked producer is eligible in the next IDLE.
REQ-030 q_val and c_data SHALL hold their last value between operations.

Reset
REQ-031 While reset_L is low: state IDLE, count 0, empty 1, full 0, all strobes, readies, c_valid and c_err 0, q_val and c_data 0, last-grant pointer = p1 (so p0 wins the first tie).
REQ-032 Reset asserted mid-operation SHALL abort it without issuing any queue strobe.

Structure
REQ-033 Package pq_pkg SHALL hold the state enum and the default W/DEPTH constants.
REQ-034 Sub-module rr_arb2 SHALL hold the 2-way round-robin grant logic and its pointer.

Verification
REQ-035 After reset, p0 and p1 are both valid with 5 and 9 -> p0_ready at cycle 1 with q_ins at cycle 2 (q_val=5), then p1_ready 3 cycles later (q_val=9).
REQ-036 Fill 6 entries, then p0_valid=1 -> full=1, count=6, p0_ready held low indefinitely.
REQ-037 Full queue with c_req and p1_valid both high -> q_pop first, c_valid with c_data=q_top, count=5, then p1 accepted.
REQ-038 Empty queue with c_req=1 -> c_err pulse, no q_pop, count stays 0.
REQ-039 clear_req during POP with count=3 -> q_clr, count=0, no c_valid, IDLE next cycle.
REQ-040 reset_L low during INS -> no q_ins, all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue arbiter.
//   W_DEFAULT     : default data width of every value path
//   DEPTH_DEFAULT : default queue capacity in entries
//   state_t       : arbiter FSM states
package pq_pkg;

  localparam int W_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE,
    INS,
    POP,
    SETTLE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its last-grant pointer.
//   clk, reset_L : clock, asynchronous active-low reset
//   req[1:0]     : request from producer 1 / producer 0
//   advance      : the grant presented on gnt is being taken this cycle
//   gnt[1:0]     : one-hot grant (combinational), zero when nobody requests
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = producer 1 was granted last; resets to 1 so producer 0 wins the first tie
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/pq_arbiter.sv
// Arbitrates two producers and one consumer onto an external priority queue.
// Each operation is IDLE (accept) -> INS/POP -> SETTLE; all outputs are registered,
// so a strobe appears the cycle after the state that decides it.
//   p0_*/p1_*          : producer offers (valid/data) and one-cycle accept pulses (ready)
//   c_req/c_valid/c_data/c_err : consumer removal request, result pulse, value, empty-error pulse
//   clear_req          : flush the queue from any state
//   q_val/q_ins/q_pop/q_clr/q_top : command interface to the queue storage
//   count/full/empty   : occupancy tracking
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic                       p0_valid,
  input  logic [W-1:0]               p0_data,
  input  logic                       p1_valid,
  input  logic [W-1:0]               p1_data,
  output logic                       p0_ready,
  output logic                       p1_ready,
  input  logic                       c_req,
  output logic                       c_valid,
  output logic [W-1:0]               c_data,
  output logic                       c_err,
  input  logic                       clear_req,
  output logic [W-1:0]               q_val,
  output logic                       q_ins,
  output logic                       q_pop,
  output logic                       q_clr,
  input  logic [W-1:0]               q_top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);

  state_t         state_q, state_d;
  logic [CW-1:0]  count_d;
  logic [W-1:0]   q_val_d, c_data_d;
  logic           p0_ready_d, p1_ready_d, c_valid_d, c_err_d;
  logic           q_ins_d, q_pop_d, q_clr_d;
  logic [1:0]     gnt;
  logic           take;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  rr_arb2 u_rr (
    .clk     (clk),
    .reset_L (reset_L),
    .req     ({p1_valid, p0_valid}),
    .advance (take),
    .gnt     (gnt)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count;
    q_val_d    = q_val;
    c_data_d   = c_data;
    p0_ready_d = 1'b0;
    p1_ready_d = 1'b0;
    c_valid_d  = 1'b0;
    c_err_d    = 1'b0;
    q_ins_d    = 1'b0;
    q_pop_d    = 1'b0;
    q_clr_d    = 1'b0;
    take       = 1'b0;

    if (clear_req) begin
      // Overrides every state: drops the in-flight strobe and c_valid
      q_clr_d = 1'b1;
      count_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_req && !empty) begin
            state_d = POP;
          end else begin
            // A request on an empty queue errors but still lets a producer in
            c_err_d = c_req;
            if (!full && (gnt != 2'b00)) begin
              take    = 1'b1;
              state_d = INS;
              if (gnt[0]) begin
                p0_ready_d = 1'b1;
                q_val_d    = p0_data;
              end else begin
                p1_ready_d = 1'b1;
                q_val_d    = p1_data;
              end
            end
          end
        end
        INS: begin
          q_ins_d = 1'b1;
          count_d = count + CW'(1);
          state_d = SETTLE;
        end
        POP: begin
          c_data_d  = q_top;
          q_pop_d   = 1'b1;
          c_valid_d = 1'b1;
          count_d   = count - CW'(1);
          state_d   = SETTLE;
        end
        SETTLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      count    <= '0;
      q_val    <= '0;
      c_data   <= '0;
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      c_valid  <= 1'b0;
      c_err    <= 1'b0;
      q_ins    <= 1'b0;
      q_pop    <= 1'b0;
      q_clr    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      q_val    <= q_val_d;
      c_data   <= c_data_d;
      p0_ready <= p0_ready_d;
      p1_ready <= p1_ready_d;
      c_valid  <= c_valid_d;
      c_err    <= c_err_d;
      q_ins    <= q_ins_d;
      q_pop    <= q_pop_d;
      q_clr    <= q_clr_d;
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
`timescale 1ns/1ps
module tb_pq_arbiter;

  localparam int W     = 8;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          p0_valid = 1'b0, p1_valid = 1'b0, c_req = 1'b0, clear_req = 1'b0;
  logic [W-1:0]  p0_data = '0, p1_data = '0, q_top = '0;
  logic          p0_ready, p1_ready, c_valid, c_err, q_ins, q_pop, q_clr, full, empty;
  logic [W-1:0]  c_data, q_val;
  logic [CW-1:0] count;

  pq_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_L(reset_L),
    .p0_valid(p0_valid), .p0_data(p0_data), .p1_valid(p1_valid), .p1_data(p1_data),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .c_req(c_req), .c_valid(c_valid), .c_data(c_data), .c_err(c_err),
    .clear_req(clear_req),
    .q_val(q_val), .q_ins(q_ins), .q_pop(q_pop), .q_clr(q_clr), .q_top(q_top),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  function automatic int max_idx(input logic [W-1:0] q[$]);
    int m = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[m]) m = i;
    return m;
  endfunction

  // Queue storage emulation answering the DUT's command strobes
  logic [W-1:0] env_q[$];
  always @(negedge clk) begin
    if (!reset_L || q_clr) env_q.delete();
    else begin
      if (q_ins) env_q.push_back(q_val);
      if (q_pop && env_q.size() > 0) env_q.delete(max_idx(env_q));
    end
    q_top = (env_q.size() > 0) ? env_q[max_idx(env_q)] : '0;
  end

  // Scoreboard of expected output events, each with the cycle it must appear in
  typedef enum int {E_RDY0, E_RDY1, E_INS, E_POP, E_ERR, E_CLR} ekind_t;
  typedef struct { int t; ekind_t k; logic [W-1:0] v; } ev_t;
  ev_t sb[$];

  function automatic void push_ev(input int t, input ekind_t k, input logic [W-1:0] v);
    ev_t e;
    e.t = t; e.k = k; e.v = v;
    sb.push_back(e);
  endfunction

  // Reference model: queue contents as a plain list, operations as 3-cycle slots
  logic [W-1:0] mdl_q[$];
  int           mdl_last = 1;
  int           free_at = 0;
  logic         s_v0 = 0, s_v1 = 0, s_creq = 0, s_clr = 0;
  logic [W-1:0] s_d0 = '0, s_d1 = '0;
  logic         acc0, acc1;

  task automatic step();
    int now, g, idx;
    @(posedge clk);
    #1;
    now = cyc;
    p0_valid = s_v0; p0_data = s_d0; p1_valid = s_v1; p1_data = s_d1;
    c_req = s_creq; clear_req = s_clr;
    acc0 = 1'b0; acc1 = 1'b0;
    if (s_clr) begin
      while (sb.size() > 0 && sb[sb.size()-1].t > now) void'(sb.pop_back());
      push_ev(now + 1, E_CLR, '0);
      mdl_q.delete();
      free_at = now + 1;
    end else if (now >= free_at) begin
      if (s_creq && mdl_q.size() > 0) begin
        idx = max_idx(mdl_q);
        push_ev(now + 2, E_POP, mdl_q[idx]);
        mdl_q.delete(idx);
        free_at = now + 3;
      end else begin
        if (s_creq) push_ev(now + 1, E_ERR, '0);
        if (mdl_q.size() < DEPTH && (s_v0 || s_v1)) begin
          if (s_v0 && s_v1) g = (mdl_last == 1) ? 0 : 1;
          else g = s_v0 ? 0 : 1;
          mdl_last = g;
          if (g == 0) begin
            push_ev(now + 1, E_RDY0, s_d0);
            push_ev(now + 2, E_INS, s_d0);
            mdl_q.push_back(s_d0);
            acc0 = 1'b1;
          end else begin
            push_ev(now + 1, E_RDY1, s_d1);
            push_ev(now + 2, E_INS, s_d1);
            mdl_q.push_back(s_d1);
            acc1 = 1'b1;
          end
          free_at = now + 3;
        end
      end
    end
  endtask

  // Monitor: pops events due this cycle and compares against what the DUT shows
  logic         mon_en = 1'b0;
  int           exp_cnt = 0;
  logic [W-1:0] exp_qval = '0, exp_cdata = '0;
  logic         e_r0, e_r1, e_ins, e_pop, e_err, e_clr;
  ev_t          mev;

  always @(negedge clk) begin
    if (mon_en) begin
      e_r0 = 0; e_r1 = 0; e_ins = 0; e_pop = 0; e_err = 0; e_clr = 0;
      while (sb.size() > 0 && sb[0].t <= cyc) begin
        mev = sb.pop_front();
        if (mev.t < cyc) chk("overdue_event", 32'(mev.k), 32'hffff_ffff);
        else begin
          case (mev.k)
            E_RDY0: begin e_r0 = 1; exp_qval = mev.v; end
            E_RDY1: begin e_r1 = 1; exp_qval = mev.v; end
            E_INS:  begin e_ins = 1; exp_cnt++; end
            E_POP:  begin e_pop = 1; exp_cdata = mev.v; exp_cnt--; end
            E_ERR:  e_err = 1;
            E_CLR:  begin e_clr = 1; exp_cnt = 0; end
            default: ;
          endcase
        end
      end
      chk("strobes{r0,r1,ins,pop,cval,err,clr}",
          32'({p0_ready, p1_ready, q_ins, q_pop, c_valid, c_err, q_clr}),
          32'({e_r0, e_r1, e_ins, e_pop, e_pop, e_err, e_clr}));
      chk("count", 32'(count), 32'(exp_cnt));
      chk("full_empty", 32'({full, empty}), 32'({exp_cnt == DEPTH, exp_cnt == 0}));
      chk("q_val", 32'(q_val), 32'(exp_qval));
      chk("c_data", 32'(c_data), 32'(exp_cdata));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"}, 32'({p0_ready, p1_ready, q_ins, q_pop, c_valid, c_err, q_clr}), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_full_empty"}, 32'({full, empty}), 32'b01);
    chk({tag, "_q_val"}, 32'(q_val), 32'd0);
    chk({tag, "_c_data"}, 32'(c_data), 32'd0);
  endtask

  initial begin
    int acc_n;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    #3 reset_L = 1'b1;
    mon_en = 1'b1;

    // Both producers valid after reset: p0 first (5), p1 three cycles later (9)
    s_v0 = 1; s_d0 = 8'd5; s_v1 = 1; s_d1 = 8'd9;
    for (int i = 0; i < 12; i++) begin
      step();
      if (acc0) s_v0 = 0;
      if (acc1) s_v1 = 0;
    end

    // Fill to capacity, then p0 stays blocked
    s_v0 = 1; s_d0 = W'($urandom);
    for (int i = 0; i < 30; i++) begin
      step();
      if (acc0) s_d0 = W'($urandom);
    end
    s_v0 = 0;

    // Full queue: pop wins, then waiting p1 gets in
    s_creq = 1; s_v1 = 1; s_d1 = 8'hee;
    step();
    s_creq = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc1) s_v1 = 0;
    end

    // Drain, then keep requesting on an empty queue
    s_creq = 1;
    for (int i = 0; i < 30; i++) step();
    s_creq = 0;

    // Three entries, then clear while the pop is in flight
    acc_n = 0;
    s_v0 = 1; s_d0 = W'($urandom);
    for (int i = 0; i < 15 && acc_n < 3; i++) begin
      step();
      if (acc0) begin acc_n++; s_d0 = W'($urandom); end
    end
    s_v0 = 0;
    for (int i = 0; i < 5; i++) step();
    s_creq = 1; step();
    s_creq = 0; s_clr = 1; step();
    s_clr = 0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!s_v0 && $urandom_range(0, 2) == 0) begin s_v0 = 1; s_d0 = W'($urandom); end
      if (!s_v1 && $urandom_range(0, 2) == 0) begin s_v1 = 1; s_d1 = W'($urandom); end
      s_creq = ($urandom_range(0, 5) == 0);
      s_clr  = ($urandom_range(0, 59) == 0);
      step();
      if (acc0) s_v0 = 0;
      if (acc1) s_v1 = 0;
    end

    // Quiesce, confirm nothing is left outstanding
    s_v0 = 0; s_v1 = 0; s_creq = 0; s_clr = 1;
    step();
    s_clr = 0;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Reset asserted during INS: no q_ins, outputs return to reset values at once
    s_v0 = 1; s_d0 = 8'h33;
    step();
    s_v0 = 0;
    step();
    chk("ins_cycle_ready", 32'(p0_ready), 32'd1);
    #1;
    mon_en = 1'b0;
    reset_L = 1'b0;
    #1 chk_reset_outputs("async_reset");
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_reset_outputs("held_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
